// File: rtl/fp_addsub_align_pkg.sv
// Shared widths and payload types for the FPU add/sub alignment front end.
// The grs field of the stage-1 payload exists only when FPU_ALIGN_GRS_EN is defined.
package fpu_addsub_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int MAX_SHIFT = 26;
  localparam int BIAS      = 127;
  localparam int SIG_W     = MAN_W + 1;
  localparam int FP_W      = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp_unpacked_t;

  typedef struct packed {
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;
`ifdef FPU_ALIGN_GRS_EN
    logic [2:0]       grs;
`endif
    logic [EXP_W-1:0] exp_a;
    logic             sign_a;
    logic             eff_sub;
  } s1_payload_t;

endpackage

// File: rtl/fp_addsub_align_if.sv
// Operand/result handshake bundle for fp_addsub_align; the design side uses the slave modport.
// The grs signal exists only when FPU_ALIGN_GRS_EN is defined.
interface fp_addsub_align_if;
  import fpu_addsub_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [FP_W-1:0]   op_a;
  logic [FP_W-1:0]   op_b;
  logic              op_sub;
  logic              out_valid;
  logic              out_ready;
  logic [SIG_W:0]    significand;
  logic [EXP_W-1:0]  exponent_a;
  logic              sign;
`ifdef FPU_ALIGN_GRS_EN
  logic [2:0]        grs;
`endif

  modport master (
`ifdef FPU_ALIGN_GRS_EN
    input  grs,
`endif
    output in_valid, op_a, op_b, op_sub, out_ready,
    input  in_ready, out_valid, significand, exponent_a, sign
  );

  modport slave (
`ifdef FPU_ALIGN_GRS_EN
    output grs,
`endif
    input  in_valid, op_a, op_b, op_sub, out_ready,
    output in_ready, out_valid, significand, exponent_a, sign
  );

endinterface

// File: rtl/fp_addsub_align_unpack.sv
// Combinational IEEE-754 unpacker: hidden bit, effective exponent and full significand.
module fp_unpack
  import fpu_addsub_pkg::*;
(
  input  logic [FP_W-1:0] op_i,
  input  logic            flip_i,
  output fp_unpacked_t    unp_o
);

  logic [EXP_W-1:0] raw_exp;
  logic             hidden;

  assign raw_exp = op_i[FP_W-2 -: EXP_W];
  assign hidden  = |raw_exp;

  // Subnormals share the scale of exponent 1 but carry no hidden bit.
  always_comb begin
    unp_o.sign = op_i[FP_W-1] ^ flip_i;
    unp_o.exp  = hidden ? raw_exp : EXP_W'(1);
    unp_o.sig  = {hidden, op_i[MAN_W-1:0]};
  end

endmodule

// File: rtl/fp_addsub_align.sv
// FPU add/sub front end: swap to larger magnitude, align, then add/sub over two stages.
// Optional FPU_ALIGN_GRS_EN keeps guard/round/sticky bits shifted out during alignment.
module fp_addsub_align
  import fpu_addsub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  fp_addsub_align_if.slave bus
);

  localparam logic [EXP_W-1:0] MAX_SHIFT_E = EXP_W'(MAX_SHIFT);

  fp_unpacked_t     unp_a, unp_b, hi_op, lo_op;
  logic             swap;
  logic [EXP_W-1:0] diff;
  s1_payload_t      s1_d, s1_q;
  logic             s1_valid_q, s1_adv, in_ready;
  logic             out_valid_q;
  logic [SIG_W:0]   sum_d, sig_q;
  logic [EXP_W-1:0] exp_q;
  logic             sign_d, sign_q;
`ifdef FPU_ALIGN_GRS_EN
  logic [SIG_W+MAX_SHIFT-1:0] ext;
  logic [SIG_W+3:0]           wide;
  logic [2:0]                 grs_d, grs_q;
`endif

  fp_unpack u_unpack_a (.op_i(bus.op_a), .flip_i(1'b0),       .unp_o(unp_a));
  fp_unpack u_unpack_b (.op_i(bus.op_b), .flip_i(bus.op_sub), .unp_o(unp_b));

  assign swap     = bus.op_b[FP_W-2:0] > bus.op_a[FP_W-2:0];
  assign s1_adv   = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s1_adv;

  // Stage 1: larger magnitude becomes A, so diff is never negative.
  always_comb begin
    hi_op = swap ? unp_b : unp_a;
    lo_op = swap ? unp_a : unp_b;
    diff  = hi_op.exp - lo_op.exp;
    s1_d  = '0;
    s1_d.sig_a   = hi_op.sig;
    s1_d.exp_a   = hi_op.exp;
    s1_d.sign_a  = hi_op.sign;
    s1_d.eff_sub = hi_op.sign ^ lo_op.sign;
`ifdef FPU_ALIGN_GRS_EN
    ext = {lo_op.sig, {MAX_SHIFT{1'b0}}} >> diff;
    if (diff >= MAX_SHIFT_E) begin
      s1_d.sig_b = '0;
      s1_d.grs   = {2'b00, |lo_op.sig};
    end else begin
      s1_d.sig_b = ext[SIG_W+MAX_SHIFT-1:MAX_SHIFT];
      s1_d.grs   = {ext[MAX_SHIFT-1], ext[MAX_SHIFT-2], |ext[MAX_SHIFT-3:0]};
    end
`else
    s1_d.sig_b = (diff >= MAX_SHIFT_E) ? '0 : (lo_op.sig >> diff);
`endif
  end

  // Stage 2: |A| >= |B| keeps the difference non-negative; exact zero is +0.
  always_comb begin
`ifdef FPU_ALIGN_GRS_EN
    wide   = s1_q.eff_sub ? ({1'b0, s1_q.sig_a, 3'b000} - {1'b0, s1_q.sig_b, s1_q.grs})
                          : ({1'b0, s1_q.sig_a, 3'b000} + {1'b0, s1_q.sig_b, s1_q.grs});
    sum_d  = wide[SIG_W+3:3];
    grs_d  = wide[2:0];
    sign_d = s1_q.sign_a && !(s1_q.eff_sub && (wide == '0));
`else
    sum_d  = s1_q.eff_sub ? ({1'b0, s1_q.sig_a} - {1'b0, s1_q.sig_b})
                          : ({1'b0, s1_q.sig_a} + {1'b0, s1_q.sig_b});
    sign_d = s1_q.sign_a && !(s1_q.eff_sub && (sum_d == '0));
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      sig_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
`ifdef FPU_ALIGN_GRS_EN
      grs_q       <= '0;
`endif
    end else begin
      if (in_ready) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (s1_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sig_q  <= sum_d;
          exp_q  <= s1_q.exp_a;
          sign_q <= sign_d;
`ifdef FPU_ALIGN_GRS_EN
          grs_q  <= grs_d;
`endif
        end
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.significand = sig_q;
  assign bus.exponent_a  = exp_q;
  assign bus.sign        = sign_q;
`ifdef FPU_ALIGN_GRS_EN
  assign bus.grs         = grs_q;
`endif

endmodule

// File: tb/tb_fp_addsub_align.sv
// Self-checking bench for fp_addsub_align: directed vectors, backpressure, random traffic
// against an arithmetic reference model, and mid-flight reset. Honors FPU_ALIGN_GRS_EN.
module tb_fp_addsub_align;
  import fpu_addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nChecks = 0;
  int nFails = 0;

  fp_addsub_align_if bus();

  fp_addsub_align dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] sig;
    logic [7:0]  exp;
    logic        sign;
    logic [2:0]  grs;
  } result_t;

  result_t expQ[$];

  // Reference: treat B as an exact fraction of 2^diff, derive guard/round/sticky from the remainder.
  function automatic result_t refModel(input logic [31:0] a, input logic [31:0] b, input logic sub);
    result_t r;
    logic [31:0] hi, lo;
    logic hiSign, loSign, effSub;
    longint eh, el, sh, sl, d, p, bint, rem, gr, st, res;
    if (b[30:0] > a[30:0]) begin
      hi = b; hiSign = b[31] ^ sub; lo = a; loSign = a[31];
    end else begin
      hi = a; hiSign = a[31]; lo = b; loSign = b[31] ^ sub;
    end
    eh = (hi[30:23] == 8'd0) ? 1 : longint'(hi[30:23]);
    el = (lo[30:23] == 8'd0) ? 1 : longint'(lo[30:23]);
    sh = ((hi[30:23] == 8'd0) ? 0 : 8388608) + longint'(hi[22:0]);
    sl = ((lo[30:23] == 8'd0) ? 0 : 8388608) + longint'(lo[22:0]);
    d = eh - el;
    if (d >= 26) begin
      bint = 0; gr = 0; st = (sl != 0) ? 1 : 0;
    end else begin
      p = longint'(1) << d;
      bint = sl / p;
      rem = sl % p;
      gr = (rem * 4) / p;
      st = (((rem * 4) % p) != 0) ? 1 : 0;
    end
    effSub = hiSign ^ loSign;
`ifdef FPU_ALIGN_GRS_EN
    res = effSub ? (sh * 8 - (bint * 8 + gr * 2 + st)) : (sh * 8 + (bint * 8 + gr * 2 + st));
    r.sig = 25'(res / 8);
    r.grs = 3'(res % 8);
`else
    res = effSub ? (sh - bint) : (sh + bint);
    r.sig = 25'(res);
    r.grs = 3'b000;
`endif
    r.exp = 8'(eh);
    r.sign = (effSub && res == 0) ? 1'b0 : hiSign;
    return r;
  endfunction

  function automatic logic [36:0] observed();
`ifdef FPU_ALIGN_GRS_EN
    return {bus.significand, bus.exponent_a, bus.sign, bus.grs};
`else
    return {bus.significand, bus.exponent_a, bus.sign, 3'b000};
`endif
  endfunction

  function automatic logic [36:0] packed_of(input result_t r);
    return {r.sig, r.exp, r.sign, r.grs};
  endfunction

  function automatic logic [31:0] randNear(input logic [31:0] base);
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 5) r[30:23] = base[30:23] - 8'($urandom_range(0, 30)) + 8'($urandom_range(0, 2));
    else if (k == 5) r[30:23] = 8'd0;
    else if (k == 6) r[30:0] = base[30:0];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.op_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nChecks++;
    if (observed() !== 37'd0 || bus.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs got valid=%b data=%h want valid=0 data=0", bus.out_valid, observed());
    end
    rst_n = 1'b1;
    @(negedge clk);
    nChecks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_release got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3FC00000};
    logic [31:0] vb [4] = '{32'h3F800000, 32'hC0400000, 32'h3F800000, 32'h30800000};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [24:0] wsig [4] = '{25'h1000000, 25'h0800000, 25'h0, 25'h0C00000};
    logic [7:0]  wexp [4] = '{8'h7F, 8'h80, 8'h7F, 8'h7F};
    logic        wsign [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
`ifdef FPU_ALIGN_GRS_EN
    logic [2:0]  wgrs [4] = '{3'b000, 3'b000, 3'b000, 3'b001};
`else
    logic [2:0]  wgrs [4] = '{3'b000, 3'b000, 3'b000, 3'b000};
`endif
    logic [36:0] want;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op_a = va[i]; bus.op_b = vb[i]; bus.op_sub = vs[i];
      @(negedge clk);
      bus.in_valid = 1'b0;
      nChecks++;
      if (bus.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL dir%0d_latency_early got out_valid=%b want 0", i, bus.out_valid);
      end
      @(negedge clk);
      want = {wsig[i], wexp[i], wsign[i], wgrs[i]};
      nChecks++;
      if (bus.out_valid !== 1'b1 || observed() !== want) begin
        nFails++;
        $display("[TB] FAIL dir%0d_result got valid=%b data=%h want valid=1 data=%h", i, bus.out_valid, observed(), want);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int recv = 0;
    expQ.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        nChecks++;
        if (expQ.size() == 0) begin
          nFails++;
          $display("[TB] FAIL bp_stale got out_valid=1 want no pending result");
        end else if (observed() !== packed_of(expQ[0])) begin
          nFails++;
          $display("[TB] FAIL bp_result cyc%0d got %h want %h", c, observed(), packed_of(expQ[0]));
        end
      end
      bus.out_ready = !(c >= 2 && c <= 5);
      bus.in_valid = (sent < 4);
      bus.op_a = $urandom; bus.op_b = randNear(bus.op_a); bus.op_sub = 1'($urandom_range(0, 1));
      #1;
      if (c == 2) begin
        nChecks++;
        if (sent !== 2 || bus.in_ready !== 1'b0) begin
          nFails++;
          $display("[TB] FAIL bp_ready_drop got accepts=%0d in_ready=%b want 2/0", sent, bus.in_ready);
        end
      end
      nChecks++;
      if (bus.in_ready !== !(expQ.size() == 2 && !bus.out_ready)) begin
        nFails++;
        $display("[TB] FAIL bp_in_ready cyc%0d got %b want %b", c, bus.in_ready, !(expQ.size() == 2 && !bus.out_ready));
      end
      if (bus.out_valid && bus.out_ready && expQ.size() > 0) begin
        void'(expQ.pop_front());
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(refModel(bus.op_a, bus.op_b, bus.op_sub));
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    nChecks++;
    if (recv !== 4 || expQ.size() !== 0) begin
      nFails++;
      $display("[TB] FAIL bp_count got recv=%0d pending=%0d want 4/0", recv, expQ.size());
    end
  endtask

  task automatic test_random();
    int recv = 0;
    int sent = 0;
    expQ.delete();
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        nChecks++;
        if (expQ.size() == 0) begin
          nFails++;
          $display("[TB] FAIL rand_stale got out_valid=1 want no pending result");
        end else if (observed() !== packed_of(expQ[0])) begin
          nFails++;
          $display("[TB] FAIL rand_result cyc%0d a=%h b=%h got %h want %h", c, bus.op_a, bus.op_b, observed(), packed_of(expQ[0]));
        end
      end
      if (c < 40) begin
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      end else if (c < 400) begin
        bus.out_ready = ($urandom_range(0, 9) < 7); bus.in_valid = ($urandom_range(0, 9) < 7);
      end else begin
        bus.out_ready = 1'b1; bus.in_valid = 1'b0;
      end
      bus.op_a = $urandom;
      if ($urandom_range(0, 7) == 0) bus.op_a[30:23] = 8'd0;
      bus.op_b = randNear(bus.op_a);
      bus.op_sub = 1'($urandom_range(0, 1));
      #1;
      nChecks++;
      if (bus.in_ready !== !(expQ.size() == 2 && !bus.out_ready)) begin
        nFails++;
        $display("[TB] FAIL rand_in_ready cyc%0d got %b want %b", c, bus.in_ready, !(expQ.size() == 2 && !bus.out_ready));
      end
      if (bus.out_valid && bus.out_ready && expQ.size() > 0) begin
        void'(expQ.pop_front());
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(refModel(bus.op_a, bus.op_b, bus.op_sub));
        sent++;
      end
      if (c == 39) begin
        nChecks++;
        if (recv !== 38) begin
          nFails++;
          $display("[TB] FAIL rand_throughput got recv=%0d want 38", recv);
        end
      end
    end
    nChecks++;
    if (expQ.size() !== 0 || recv !== sent) begin
      nFails++;
      $display("[TB] FAIL rand_drain got pending=%0d recv=%0d want 0/%0d", expQ.size(), recv, sent);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.op_a = 32'h3F800000; bus.op_b = 32'h40000000; bus.op_sub = 1'b0;
    @(negedge clk);
    bus.op_a = 32'h40400000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    nChecks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL mid_full got out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    nChecks++;
    if (bus.out_valid !== 1'b0 || observed() !== 37'd0) begin
      nFails++;
      $display("[TB] FAIL mid_reset got valid=%b data=%h want 0/0", bus.out_valid, observed());
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    nChecks++;
    if (bus.in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL mid_in_ready got %b want 1", bus.in_ready);
    end
    expQ.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nChecks++;
      if (bus.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL mid_stale cyc%0d got out_valid=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
